mem_bank_2r1w: RTL and testbench

- Parametrised successor to the team's single-port memory: one synchronous write port with byte-lane enables and two asynchronous read ports.
- Built-in clear engine zeroes every entry after reset or on request, one entry per cycle, and signals progress on `busy`.
- Optional write-to-read bypass.
- Used as the register bank and scratch memory in the datapath. Any read port may be tied off.

---
 rtl/mem_bank_pkg.sv | 12 +
 rtl/mem_clear_ctrl.sv | 59 +++++
 rtl/mem_bank_2r1w.sv | 96 +++++++++
 tb/tb_mem_bank_2r1w.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bank_pkg.sv
// Shared definitions for the two-read/one-write memory bank.
// Holds the clear-engine state encoding and the byte-lane count helper.
package mem_bank_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SWEEP = 1'b1;

  function automatic int unsigned lane_count(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/mem_clear_ctrl.sv
// Clear engine for mem_bank_2r1w: walks every address once, issuing a zero write per cycle.
// A sweep starts on reset or on a clear request while idle.
module mem_clear_ctrl
  import mem_bank_pkg::*;
#(
  parameter int unsigned N = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  output logic         busy_o,
  output logic         clr_we_o,
  output logic [N-1:0] clr_addr_o
);

  logic         state_q, state_d;
  logic [N-1:0] ptr_q, ptr_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
        end
      end
      ST_SWEEP: begin
        ptr_d = ptr_q + 1'b1;
        // Terminal entry is still written this cycle; drop to idle afterwards.
        if (ptr_q == {N{1'b1}}) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_SWEEP;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy_o     = (state_q == ST_SWEEP);
  // No array write on the reset edge itself.
  assign clr_we_o   = busy_o & ~rst_i;
  assign clr_addr_o = ptr_q;

endmodule

// File: rtl/mem_bank_2r1w.sv
// Memory bank with one byte-enabled synchronous write port and two combinational read ports.
// The clear engine owns the write port while busy; reads return zero during a sweep.
module mem_bank_2r1w
  import mem_bank_pkg::*;
#(
  parameter int unsigned M      = 32,
  parameter int unsigned N      = 10,
  parameter int unsigned BYPASS = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  output logic                     busy,
  input  logic                     we,
  input  logic [lane_count(M)-1:0] be,
  input  logic [N-1:0]             waddr,
  input  logic [M-1:0]             memin,
  input  logic [N-1:0]             raddr0,
  output logic [M-1:0]             memout0,
  input  logic [N-1:0]             raddr1,
  output logic [M-1:0]             memout1
);

  localparam int unsigned Lanes = lane_count(M);
  localparam int unsigned Depth = 2 ** N;

  if (M % 8 != 0) begin : g_width_check
    $error("mem_bank_2r1w: M (%0d) must be a multiple of 8", M);
  end

  logic [M-1:0] mem_q [Depth];

  logic         clr_we;
  logic [N-1:0] clr_addr;
  logic         user_we;
  logic         wr_en;
  logic [N-1:0] wr_addr;
  logic [M-1:0] wr_data;

  function automatic logic [M-1:0] merge_lanes(input logic [M-1:0]     old_w,
                                               input logic [M-1:0]     new_w,
                                               input logic [Lanes-1:0] en);
    logic [M-1:0] res;
    res = old_w;
    for (int unsigned j = 0; j < Lanes; j++) begin
      if (en[j]) res[8*j +: 8] = new_w[8*j +: 8];
    end
    return res;
  endfunction

  mem_clear_ctrl #(
    .N (N)
  ) u_clear_ctrl (
    .clk_i      (clock),
    .rst_i      (reset),
    .clear_i    (clear),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // Clear requests win over a same-cycle user write.
  assign user_we = we & ~busy & ~clear & ~reset;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = waddr;
    wr_data = mem_q[waddr];
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = '0;
    end else if (user_we) begin
      wr_en   = 1'b1;
      wr_data = merge_lanes(mem_q[waddr], memin, be);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_comb begin
    memout0 = mem_q[raddr0];
    memout1 = mem_q[raddr1];
    if (BYPASS != 0 && user_we) begin
      if (raddr0 == waddr) memout0 = merge_lanes(mem_q[raddr0], memin, be);
      if (raddr1 == waddr) memout1 = merge_lanes(mem_q[raddr1], memin, be);
    end
    if (busy) begin
      memout0 = '0;
      memout1 = '0;
    end
  end

endmodule

// File: tb/tb_mem_bank_2r1w.sv
// Randomised and directed checks of mem_bank_2r1w (M=32, N=4) against a behavioural model,
// with one instance built without bypass and one with bypass sharing the same stimulus.
module tb_mem_bank_2r1w;

  logic        clock;
  logic        reset, clear, we;
  logic [3:0]  be;
  logic [3:0]  waddr, raddr0, raddr1;
  logic [31:0] memin;
  logic        busy, busy_b;
  logic [31:0] memout0, memout1, memout0_b, memout1_b;

  int vectors     = 0;
  int miscompares = 0;

  // Model: contents plus number of busy cycles still to run.
  logic [31:0] model [16];
  int          rem = 0;

  mem_bank_2r1w #(.M(32), .N(4), .BYPASS(0)) dut (
    .clock(clock), .reset(reset), .clear(clear), .busy(busy), .we(we), .be(be),
    .waddr(waddr), .memin(memin), .raddr0(raddr0), .memout0(memout0),
    .raddr1(raddr1), .memout1(memout1)
  );

  mem_bank_2r1w #(.M(32), .N(4), .BYPASS(1)) dut_b (
    .clock(clock), .reset(reset), .clear(clear), .busy(busy_b), .we(we), .be(be),
    .waddr(waddr), .memin(memin), .raddr0(raddr0), .memout0(memout0_b),
    .raddr1(raddr1), .memout1(memout1_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] exp_rd(input logic [3:0] a, input bit byp);
    logic [31:0] r;
    if (rem > 0) return 32'h0;
    r = model[a];
    if (byp && we && !clear && !reset && a == waddr) begin
      for (int j = 0; j < 4; j++) if (be[j]) r[8*j +: 8] = memin[8*j +: 8];
    end
    return r;
  endfunction

  task automatic tick();
    logic        r, c, w;
    logic [3:0]  b, a;
    logic [31:0] d;
    r = reset; c = clear; w = we; b = be; a = waddr; d = memin;
    @(posedge clock);
    if (r) rem = 16;
    else if (rem == 0 && c) rem = 16;
    else if (rem > 0) begin
      rem--;
      if (rem == 0) for (int i = 0; i < 16; i++) model[i] = 32'h0;
    end else if (w) begin
      for (int j = 0; j < 4; j++) if (b[j]) model[a][8*j +: 8] = d[8*j +: 8];
    end
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; clear = 1'b0; we = 1'b0; be = 4'h0; waddr = 4'h0; memin = 32'h0;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    we = 1'b1; waddr = a; memin = d; be = b;
    tick();
    we = 1'b0; be = 4'h0;
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    raddr0 = 4'h0; raddr1 = 4'h0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL reset_busy: got %b want 1", busy);
    end
    vectors++;
    if (memout0 !== 32'h0) begin
      miscompares++; $display("FAIL reset_memout0: got %h want 0", memout0);
    end
    n = 0;
    while (busy && n < 64) begin tick(); n++; end
    vectors++;
    if (n !== 16) begin
      miscompares++; $display("FAIL reset_busy_len: got %0d cycles want 16", n);
    end
    for (int i = 0; i < 16; i++) begin
      raddr0 = 4'(i); raddr1 = 4'(15 - i);
      #1;
      vectors++;
      if (memout0 !== 32'h0 || memout1 !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_cleared[%0d]: got %h/%h want 0/0", i, memout0, memout1);
      end
    end
  endtask

  task automatic test_byte_lane();
    write_word(4'd3, 32'hAABBCCDD, 4'b1111);
    write_word(4'd3, 32'h11223344, 4'b0101);
    raddr0 = 4'd3;
    #1;
    vectors++;
    if (memout0 !== 32'hAA22CC44) begin
      miscompares++; $display("FAIL byte_lane: got %h want aa22cc44", memout0);
    end
    write_word(4'd3, 32'hFFFFFFFF, 4'b0000);
    #1;
    vectors++;
    if (memout0 !== 32'hAA22CC44) begin
      miscompares++; $display("FAIL byte_lane_be0: got %h want aa22cc44", memout0);
    end
  endtask

  task automatic test_dual_read();
    write_word(4'd5, 32'h5, 4'hF);
    write_word(4'd9, 32'h9, 4'hF);
    raddr0 = 4'd5; raddr1 = 4'd9;
    #1;
    vectors++;
    if (memout0 !== 32'h5 || memout1 !== 32'h9) begin
      miscompares++; $display("FAIL dual_read: got %h/%h want 5/9", memout0, memout1);
    end
    raddr0 = 4'd9;
    #1;
    vectors++;
    if (memout0 !== 32'h9 || memout1 !== 32'h9) begin
      miscompares++; $display("FAIL dual_same: got %h/%h want 9/9", memout0, memout1);
    end
  endtask

  task automatic test_clear_write();
    int n;
    write_word(4'd2, 32'hFF, 4'hF);
    clear = 1'b1; we = 1'b1; waddr = 4'd7; memin = 32'h77; be = 4'hF;
    tick();
    idle_inputs();
    n = 0;
    while (busy && n < 64) begin tick(); n++; end
    vectors++;
    if (n !== 16) begin
      miscompares++; $display("FAIL clear_busy_len: got %0d cycles want 16", n);
    end
    raddr0 = 4'd2; raddr1 = 4'd7;
    #1;
    vectors++;
    if (memout0 !== 32'h0 || memout1 !== 32'h0) begin
      miscompares++; $display("FAIL clear_contents: got %h/%h want 0/0", memout0, memout1);
    end
  endtask

  task automatic test_clear_mid_sweep();
    int n;
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (5) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    n = 0;
    while (busy && n < 64) begin tick(); n++; end
    vectors++;
    if (6 + n !== 16) begin
      miscompares++; $display("FAIL clear_mid_sweep_len: got %0d cycles want 16", 6 + n);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (6) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    n = 0;
    while (busy && n < 64) begin tick(); n++; end
    vectors++;
    if (n !== 16) begin
      miscompares++; $display("FAIL reset_mid_sweep_len: got %0d cycles want 16", n);
    end
  endtask

  task automatic test_bypass();
    write_word(4'd4, 32'h01020304, 4'hF);
    we = 1'b1; waddr = 4'd4; memin = 32'hA0B0C0D0; be = 4'b0011; raddr1 = 4'd4;
    #1;
    vectors++;
    if (memout1_b !== 32'h0102C0D0) begin
      miscompares++; $display("FAIL bypass_on: got %h want 0102c0d0", memout1_b);
    end
    vectors++;
    if (memout1 !== 32'h01020304) begin
      miscompares++; $display("FAIL bypass_off: got %h want 01020304", memout1);
    end
    tick();
    we = 1'b0; be = 4'h0;
    #1;
    vectors++;
    if (memout1 !== 32'h0102C0D0 || memout1_b !== 32'h0102C0D0) begin
      miscompares++;
      $display("FAIL bypass_after: got %h/%h want 0102c0d0", memout1, memout1_b);
    end
  endtask

  task automatic test_random();
    logic [31:0] e00, e01, e10, e11;
    for (int c = 0; c < 400; c++) begin
      reset  = ($urandom_range(0, 199) == 0);
      clear  = ($urandom_range(0, 59) == 0);
      we     = ($urandom_range(0, 3) != 0);
      be     = 4'($urandom);
      waddr  = 4'($urandom);
      memin  = $urandom;
      raddr0 = ($urandom_range(0, 2) == 0) ? waddr : 4'($urandom);
      raddr1 = ($urandom_range(0, 1) == 0) ? waddr : 4'($urandom);
      #1;
      e00 = exp_rd(raddr0, 1'b0); e01 = exp_rd(raddr1, 1'b0);
      e10 = exp_rd(raddr0, 1'b1); e11 = exp_rd(raddr1, 1'b1);
      vectors++;
      if (busy !== (rem > 0) || busy_b !== (rem > 0)) begin
        miscompares++;
        $display("FAIL rand_busy[%0d]: got %b/%b want %b", c, busy, busy_b, rem > 0);
      end
      vectors++;
      if (memout0 !== e00 || memout1 !== e01) begin
        miscompares++;
        $display("FAIL rand_rd[%0d]: got %h/%h want %h/%h", c, memout0, memout1, e00, e01);
      end
      vectors++;
      if (memout0_b !== e10 || memout1_b !== e11) begin
        miscompares++;
        $display("FAIL rand_rd_byp[%0d]: got %h/%h want %h/%h", c, memout0_b, memout1_b,
                 e10, e11);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    raddr0 = 4'h0; raddr1 = 4'h0;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    @(negedge clock);
    test_reset();
    test_byte_lane();
    test_dual_read();
    test_clear_write();
    test_clear_mid_sweep();
    test_reset_mid_sweep();
    test_bypass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
